// File: rtl/ram_arbiter.sv
// N-port arbiter in front of a single-port SRAM.
// Grants one requester per cycle, using fixed priority or round-robin.
// Returns a per-port response valid RAM_LATENCY cycles after each grant.
module ram_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned RR_EN       = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              port_req_i,
  output logic [NUM_PORTS-1:0]              port_gnt_o,
  output logic [NUM_PORTS-1:0]              port_rvalid_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr_i,
  input  logic [NUM_PORTS-1:0]              port_we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_wdata_i,
  output logic [DATA_WIDTH-1:0]             port_rdata_o,
  output logic                              ram_en_o,
  output logic [ADDR_WIDTH-1:0]             ram_addr_o,
  output logic                              ram_we_o,
  output logic [DATA_WIDTH/8-1:0]           ram_be_o,
  output logic [DATA_WIDTH-1:0]             ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]             ram_rdata_i
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } rsp_t;

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] scan_idx;
  logic [31:0]      scan_sum;
  logic             gnt_any;
  rsp_t             pipe_q [RAM_LATENCY];

  // Scan requesters starting at the priority pointer, wrapping around
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      scan_sum = 32'(rr_q) + i;
      if (scan_sum >= NUM_PORTS) begin
        scan_sum = scan_sum - NUM_PORTS;
      end
      scan_idx = IDX_W'(scan_sum);
      if (!gnt_any && port_req_i[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // One-hot grant decode
  always_comb begin
    port_gnt_o = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      port_gnt_o[k] = gnt_any && (gnt_idx == IDX_W'(k));
    end
  end

  // RAM drive: granted port's fields, forced to zero when idle
  always_comb begin
    ram_en_o    = |port_req_i;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (gnt_any) begin
      ram_addr_o  = port_addr_i[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
      ram_we_o    = port_we_i[gnt_idx];
      ram_be_o    = port_be_i[32'(gnt_idx) * BE_W +: BE_W];
      ram_wdata_o = port_wdata_i[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next priority pointer: one past the winner in round-robin mode
  always_comb begin
    rr_d = rr_q;
    if ((RR_EN != 0) && gnt_any) begin
      rr_d = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Response pipeline tracking which port each RAM access belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{vld: gnt_any, idx: gnt_idx};
      for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Response valid decode from the last pipeline stage
  always_comb begin
    port_rvalid_o = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      port_rvalid_o[k] = pipe_q[RAM_LATENCY-1].vld &&
                         (pipe_q[RAM_LATENCY-1].idx == IDX_W'(k));
    end
  end

  assign port_rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: three instances (RR/L1, fixed/L3, 3-port RR/L3)
// with RAM models; responses are checked against a scoreboard of expectations.
module tb_ram_arbiter;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb [3][$];

  // Instance A: 4 ports, round-robin, latency 1
  logic         a_rst;
  logic [3:0]   a_req, a_gnt, a_rv, a_we;
  logic [127:0] a_addr, a_wdata;
  logic [15:0]  a_be;
  logic [31:0]  a_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata, a_rd_q;
  logic         a_ram_en, a_ram_we;
  logic [3:0]   a_ram_be;

  // Instance B: 4 ports, fixed priority, latency 3
  logic         b_rst;
  logic [3:0]   b_req, b_gnt, b_rv, b_we;
  logic [127:0] b_addr, b_wdata;
  logic [15:0]  b_be;
  logic [31:0]  b_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic         b_ram_en, b_ram_we;
  logic [3:0]   b_ram_be;
  logic [31:0]  mem_b [0:63];
  logic [31:0]  b_rd  [3];

  // Instance C: 3 ports, round-robin, latency 3
  logic         c_rst;
  logic [2:0]   c_req, c_gnt, c_rv, c_we;
  logic [95:0]  c_addr, c_wdata;
  logic [11:0]  c_be;
  logic [31:0]  c_rdata, c_ram_addr, c_ram_wdata;
  logic [31:0]  c_ram_rdata = 32'h1234_5678;
  logic         c_ram_en, c_ram_we;
  logic [3:0]   c_ram_be;

  ram_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(1), .RR_EN(1)) u_a (
    .clk(clk), .rst(a_rst), .port_req_i(a_req), .port_gnt_o(a_gnt), .port_rvalid_o(a_rv),
    .port_addr_i(a_addr), .port_we_i(a_we), .port_be_i(a_be), .port_wdata_i(a_wdata),
    .port_rdata_o(a_rdata), .ram_en_o(a_ram_en), .ram_addr_o(a_ram_addr), .ram_we_o(a_ram_we),
    .ram_be_o(a_ram_be), .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata));

  ram_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(3), .RR_EN(0)) u_b (
    .clk(clk), .rst(b_rst), .port_req_i(b_req), .port_gnt_o(b_gnt), .port_rvalid_o(b_rv),
    .port_addr_i(b_addr), .port_we_i(b_we), .port_be_i(b_be), .port_wdata_i(b_wdata),
    .port_rdata_o(b_rdata), .ram_en_o(b_ram_en), .ram_addr_o(b_ram_addr), .ram_we_o(b_ram_we),
    .ram_be_o(b_ram_be), .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata));

  ram_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LATENCY(3), .RR_EN(1)) u_c (
    .clk(clk), .rst(c_rst), .port_req_i(c_req), .port_gnt_o(c_gnt), .port_rvalid_o(c_rv),
    .port_addr_i(c_addr), .port_we_i(c_we), .port_be_i(c_be), .port_wdata_i(c_wdata),
    .port_rdata_o(c_rdata), .ram_en_o(c_ram_en), .ram_addr_o(c_ram_addr), .ram_we_o(c_ram_we),
    .ram_be_o(c_ram_be), .ram_wdata_o(c_ram_wdata), .ram_rdata_i(c_ram_rdata));

  // RAM A: read-only, word content derived from its address, latency 1
  always @(posedge clk) a_rd_q <= 32'hC0DE_0000 | a_ram_addr;
  assign a_ram_rdata = a_rd_q;

  // RAM B: byte-writable array, read latency 3
  always @(posedge clk) begin
    if (b_ram_en && b_ram_we) begin
      for (int j = 0; j < 4; j++) begin
        if (b_ram_be[j]) mem_b[b_ram_addr[7:2]][j*8 +: 8] <= b_ram_wdata[j*8 +: 8];
      end
    end
    b_rd[0] <= mem_b[b_ram_addr[7:2]];
    b_rd[1] <= b_rd[0];
    b_rd[2] <= b_rd[1];
  end
  assign b_ram_rdata = b_rd[2];

  logic [3:0]  rv_m [3];
  logic [31:0] rd_m [3];
  assign rv_m[0] = a_rv;
  assign rv_m[1] = b_rv;
  assign rv_m[2] = {1'b0, c_rv};
  assign rd_m[0] = a_rdata;
  assign rd_m[1] = b_rdata;
  assign rd_m[2] = c_rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops expected responses and compares rvalid/rdata each cycle
  task automatic run_monitor();
    logic [3:0]  e;
    logic [31:0] d;
    bit          chk;
    bit          pop;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        e = '0; d = '0; chk = 1'b0; pop = 1'b0;
        while (sb[k].size() > 0 && sb[k][0].cyc < cyc) begin
          n_cmp++; n_err++;
          $display("FAIL rvalid_missed inst %0d: port %0d due cycle %0d, now %0d",
                   k, sb[k][0].port, sb[k][0].cyc, cyc);
          void'(sb[k].pop_front());
        end
        if (sb[k].size() > 0 && sb[k][0].cyc == cyc) begin
          e[sb[k][0].port] = 1'b1;
          d   = sb[k][0].data;
          chk = sb[k][0].chk;
          pop = 1'b1;
        end
        if (e != 4'b0 || rv_m[k] !== 4'b0) begin
          n_cmp++;
          if (rv_m[k] !== e) begin
            n_err++;
            $display("FAIL rvalid inst %0d cycle %0d: got %b expected %b", k, cyc, rv_m[k], e);
          end
        end
        if (chk) begin
          n_cmp++;
          if (rd_m[k] !== d) begin
            n_err++;
            $display("FAIL rdata inst %0d cycle %0d: got %h expected %h", k, cyc, rd_m[k], d);
          end
        end
        if (pop) void'(sb[k].pop_front());
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_req = '0; b_req = '0; c_req = '0;
    a_addr = {$urandom, $urandom, $urandom, 32'hFFFF_FFFF};
    a_we = 4'hF; a_be = '1; a_wdata = {4{32'hA5A5_A5A5}};
    b_addr = '0; b_we = '0; b_be = '0; b_wdata = '0;
    c_addr = '0; c_we = '0; c_be = '0; c_wdata = '0;
    @(negedge clk);
    n_cmp++; if (a_gnt !== 4'b0)      begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", a_gnt); end
    n_cmp++; if (a_ram_en !== 1'b0)   begin n_err++; $display("FAIL reset_ram_en: got %b expected 0", a_ram_en); end
    n_cmp++; if (a_ram_addr !== 32'h0) begin n_err++; $display("FAIL reset_ram_addr: got %h expected 0", a_ram_addr); end
    n_cmp++; if (a_ram_we !== 1'b0)   begin n_err++; $display("FAIL reset_ram_we: got %b expected 0", a_ram_we); end
    n_cmp++; if (a_ram_be !== 4'h0)   begin n_err++; $display("FAIL reset_ram_be: got %h expected 0", a_ram_be); end
    n_cmp++; if (a_ram_wdata !== 32'h0) begin n_err++; $display("FAIL reset_ram_wdata: got %h expected 0", a_ram_wdata); end
    n_cmp++; if (c_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL reset_rdata_pass: got %h expected 12345678", c_rdata); end
    // Grant during reset is visible but must not enter the pipeline or move the pointer
    @(posedge clk); #1;
    a_req = 4'b0100;
    @(negedge clk);
    n_cmp++; if (a_gnt !== 4'b0100) begin n_err++; $display("FAIL reset_gnt_comb: got %b expected 0100", a_gnt); end
    n_cmp++; if (a_ram_en !== 1'b1) begin n_err++; $display("FAIL reset_ram_en_comb: got %b expected 1", a_ram_en); end
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_req = '0; a_we = '0;
    @(negedge clk);
    n_cmp++; if (a_rv !== 4'b0) begin n_err++; $display("FAIL reset_rvalid_a: got %b expected 0000", a_rv); end
    n_cmp++; if (b_rv !== 4'b0) begin n_err++; $display("FAIL reset_rvalid_b: got %b expected 0000", b_rv); end
    n_cmp++; if (c_rv !== 3'b0) begin n_err++; $display("FAIL reset_rvalid_c: got %b expected 000", c_rv); end
  endtask

  task automatic test_rr_fairness();
    logic [3:0] eg;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) a_addr[k*32 +: 32] = 32'(k * 4 + 32'h100);
    a_we = '0;
    a_req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      eg = 4'b0001 << (i % 4);
      sb[0].push_back('{cyc + 1, i % 4, 32'hC0DE_0000 | 32'((i % 4) * 4 + 32'h100), 1'b1});
      @(negedge clk);
      n_cmp++;
      if (a_gnt !== eg) begin n_err++; $display("FAIL rr_gnt step %0d: got %b expected %b", i, a_gnt, eg); end
    end
    @(posedge clk); #1;
    a_req = '0;
    wait_cycles(2);
  endtask

  task automatic test_single_request();
    @(posedge clk); #1;
    a_addr[2*32 +: 32] = 32'h40;
    a_we = '0;
    a_req = 4'b0100;
    sb[0].push_back('{cyc + 1, 2, 32'hC0DE_0040, 1'b1});
    @(negedge clk);
    n_cmp++; if (a_gnt !== 4'b0100)     begin n_err++; $display("FAIL single_gnt: got %b expected 0100", a_gnt); end
    n_cmp++; if (a_ram_addr !== 32'h40) begin n_err++; $display("FAIL single_addr: got %h expected 40", a_ram_addr); end
    n_cmp++; if (a_ram_we !== 1'b0)     begin n_err++; $display("FAIL single_we: got %b expected 0", a_ram_we); end
    @(posedge clk); #1;
    a_req = '0;
    wait_cycles(2);
  endtask

  task automatic test_fixed_priority();
    @(posedge clk); #1;
    b_req = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      sb[1].push_back('{cyc + 3, 0, 32'h0, 1'b0});
      @(negedge clk);
      n_cmp++;
      if (b_gnt !== 4'b0001) begin n_err++; $display("FAIL fixed_gnt step %0d: got %b expected 0001", i, b_gnt); end
    end
    @(posedge clk); #1;
    b_req = 4'b0010;
    sb[1].push_back('{cyc + 3, 1, 32'h0, 1'b0});
    @(negedge clk);
    n_cmp++; if (b_gnt !== 4'b0010) begin n_err++; $display("FAIL fixed_release: got %b expected 0010", b_gnt); end
    @(posedge clk); #1;
    b_req = '0;
    wait_cycles(4);
  endtask

  task automatic test_latency_writes();
    @(posedge clk); #1;
    b_addr[1*32 +: 32] = 32'h10;
    b_wdata[1*32 +: 32] = 32'hDEAD_BEEF;
    b_be[1*4 +: 4] = 4'hF;
    b_we = 4'b0010;
    b_req = 4'b0010;
    sb[1].push_back('{cyc + 3, 1, 32'h0, 1'b0});
    @(negedge clk);
    n_cmp++; if (b_ram_we !== 1'b1)            begin n_err++; $display("FAIL wr_we: got %b expected 1", b_ram_we); end
    n_cmp++; if (b_ram_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_wdata: got %h expected deadbeef", b_ram_wdata); end
    n_cmp++; if (b_ram_be !== 4'hF)            begin n_err++; $display("FAIL wr_be: got %h expected f", b_ram_be); end
    n_cmp++; if (b_ram_addr !== 32'h10)        begin n_err++; $display("FAIL wr_addr: got %h expected 10", b_ram_addr); end
    @(posedge clk); #1;
    b_we = '0;
    b_addr[3*32 +: 32] = 32'h10;
    b_req = 4'b1000;
    sb[1].push_back('{cyc + 3, 3, 32'hDEAD_BEEF, 1'b1});
    @(negedge clk);
    n_cmp++; if (b_gnt !== 4'b1000) begin n_err++; $display("FAIL rd_gnt: got %b expected 1000", b_gnt); end
    n_cmp++; if (b_ram_we !== 1'b0) begin n_err++; $display("FAIL rd_we: got %b expected 0", b_ram_we); end
    @(posedge clk); #1;
    b_req = '0;
    wait_cycles(5);
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    c_req = 3'b001;
    @(negedge clk);
    n_cmp++; if (c_gnt !== 3'b001) begin n_err++; $display("FAIL mid_gnt0: got %b expected 001", c_gnt); end
    @(posedge clk); #1;
    c_req = 3'b010;
    @(negedge clk);
    n_cmp++; if (c_gnt !== 3'b010) begin n_err++; $display("FAIL mid_gnt1: got %b expected 010", c_gnt); end
    @(posedge clk); #1;
    c_req = 3'b000;
    c_rst = 1'b1;
    @(posedge clk); #1;
    c_rst = 1'b0;
    c_req = 3'b111;
    sb[2].push_back('{cyc + 3, 0, 32'h0, 1'b0});
    @(negedge clk);
    n_cmp++; if (c_gnt !== 3'b001) begin n_err++; $display("FAIL mid_after_reset: got %b expected 001", c_gnt); end
    @(posedge clk); #1;
    c_req = '0;
    wait_cycles(5);
  endtask

  task automatic test_pointer_wrap();
    logic [2:0] exp_g [3];
    logic [2:0] reqs  [3];
    int         prt   [3];
    exp_g[0] = 3'b100; exp_g[1] = 3'b001; exp_g[2] = 3'b100;
    reqs[0]  = 3'b100; reqs[1]  = 3'b101; reqs[2]  = 3'b101;
    prt[0]   = 2;      prt[1]   = 0;      prt[2]   = 2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      c_req = reqs[i];
      sb[2].push_back('{cyc + 3, prt[i], 32'h0, 1'b0});
      @(negedge clk);
      n_cmp++;
      if (c_gnt !== exp_g[i]) begin n_err++; $display("FAIL wrap_gnt step %0d: got %b expected %b", i, c_gnt, exp_g[i]); end
    end
    @(posedge clk); #1;
    c_req = '0;
    wait_cycles(5);
  endtask

  initial begin
    test_reset();
    fork
      run_monitor();
    join_none
    test_rr_fairness();
    test_single_request();
    test_fixed_priority();
    test_latency_writes();
    test_reset_midflight();
    test_pointer_wrap();
    wait_cycles(4);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (sb[k].size() != 0) begin
        n_err++;
        $display("FAIL sb_drain inst %0d: got %0d pending expected 0", k, sb[k].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised N-port arbiter in front of a single-port SRAM, successor to the two-port fixed-priority data-RAM mux. It grants at most one requester per cycle, under either fixed priority or round-robin. It drives the RAM directly and returns a per-port `rvalid` after a configurable RAM read latency. It sits between the core LSU, instruction/debug ports and the AXI-to-mem bridge, and the SRAM macro.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width, multiple of 8.
- `RAM_LATENCY`, 1: cycles from RAM enable to valid `ram_rdata_i`, 1..4.
- `RR_EN`, 1: 1 selects round-robin, 0 selects fixed priority (port 0 highest).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `port_req_i` in NUM_PORTS: request, bit k belongs to port k.
- `port_gnt_o` out NUM_PORTS: grant, one-hot or zero.
- `port_rvalid_o` out NUM_PORTS: response valid, one-hot or zero.
- `port_addr_i` in NUM_PORTS*ADDR_WIDTH: port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- `port_we_i` in NUM_PORTS: write enable.
- `port_be_i` in NUM_PORTS*DATA_WIDTH/8: byte enables.
- `port_wdata_i` in NUM_PORTS*DATA_WIDTH: write data.
- `port_rdata_o` out DATA_WIDTH: read data, broadcast to all ports; qualified only by that port's `port_rvalid_o`.
- `ram_en_o` out 1: RAM access enable.
- `ram_addr_o` out ADDR_WIDTH: RAM address.
- `ram_we_o` out 1: RAM write enable.
- `ram_be_o` out DATA_WIDTH/8: RAM byte enables.
- `ram_wdata_o` out DATA_WIDTH: RAM write data.
- `ram_rdata_i` in DATA_WIDTH: RAM read data.

## Operation
- **Grant is combinational** from `port_req_i` and the priority pointer `rr_q`. `port_gnt_o[k]=1` iff port k is the first requester found scanning k = rr_q, rr_q+1, …, wrapping modulo NUM_PORTS.
- **Fixed-priority mode** (RR_EN=0): `rr_q` is held at 0.
- **Round-robin mode** (RR_EN=1): on a cycle with a grant to port g, `rr_q` ← (g+1) mod NUM_PORTS. With no grant, `rr_q` holds. Wrap from NUM_PORTS-1 goes to 0.
- **RAM drive:** `ram_en_o = |port_req_i`. `ram_addr_o`, `ram_we_o`, `ram_be_o` and `ram_wdata_o` carry the granted port's fields. With no request these outputs are all zero, not a stale mux value.
- **Response pipeline:** RAM_LATENCY stages, each holding a valid bit and a grant index of width $clog2(NUM_PORTS), minimum 1.
  - Stage 0 loads {|port_gnt_o, granted index}.
  - The last stage drives `port_rvalid_o` (one-hot decode when valid).
- **Writes also produce `rvalid`**, exactly as reads do. Ports count responses, not reads.
- **`port_rdata_o = ram_rdata_i`** unconditionally.
- **Back-to-back grants:** one grant per cycle sustained; no bubbles inserted.
- **Ungranted ports:** a requester that is not granted keeps `req` and its fields stable until granted. The arbiter does not latch requests.
- **Reset** (`rst`=1 at a rising edge):
  - `rr_q` ← 0 and all pipeline valid bits ← 0.
  - In-flight responses are dropped; no `rvalid` is produced for them after reset.
  - During reset cycles `port_gnt_o` still follows requests combinationally, but those grants are not entered into the pipeline and do not advance `rr_q`.

## Timing
- `port_gnt_o` and `ram_*` outputs: same cycle as `port_req_i`, zero latency.
- `port_rvalid_o[g]`: exactly RAM_LATENCY cycles after the cycle `port_gnt_o[g]`=1.
- **Reset values:**
  - `port_rvalid_o`=0.
  - `port_gnt_o`, `ram_en_o`, `ram_we_o`, `ram_be_o`, `ram_addr_o` and `ram_wdata_o` are 0 while `port_req_i`=0.
  - `port_rdata_o` follows `ram_rdata_i`.
- **Simultaneous events:**
  - All ports requesting every cycle in RR mode: grants rotate 0,1,…,N-1,0. The maximum wait for any port is NUM_PORTS-1 cycles.
  - A new grant in the same cycle as an `rvalid` to the same port is legal.

## Test plan
- **Single request:** NUM_PORTS=4, RAM_LATENCY=1, port 2 reads addr 0x40 for one cycle.
  - Same cycle: `port_gnt_o`=4'b0100, `ram_addr_o`=0x40, `ram_we_o`=0.
  - Next cycle: `port_rvalid_o`=4'b0100 and `port_rdata_o`=RAM word.
- **Round-robin fairness:** RR_EN=1, `port_req_i`=4'b1111 held 8 cycles from reset.
  - Grants: ports 0,1,2,3,0,1,2,3.
  - `rvalid` is the same sequence delayed by RAM_LATENCY.
- **Fixed priority and starvation:** RR_EN=0, `port_req_i`=4'b0011 held 5 cycles.
  - Port 0 granted all 5 cycles; port 1 never.
  - Drop port 0: port 1 granted next cycle.
- **Latency and writes:** RAM_LATENCY=3, port 1 writes 0xDEADBEEF with be=4'b1111 to 0x10, then port 3 reads 0x10.
  - `rvalid` to port 1 at cycle t+3 and to port 3 at t+4.
  - Port 3 rdata = 0xDEADBEEF.
- **Reset mid-flight:** RAM_LATENCY=3, grants to ports 0 and 1 on consecutive cycles, then `rst`=1 one cycle later.
  - No `rvalid` afterwards.
  - After reset, the next grant with all ports requesting goes to port 0.
- **Pointer wrap:** RR_EN=1, NUM_PORTS=3, last grant to port 2, then `port_req_i`=3'b101.
  - Grant goes to port 0, then port 2.
